// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
// Speculative return-address stack living in fetch stage F1 next to the
// return-PC table. A predicted call pushes its return address and a predicted
// jr $ra pops. Fetch reads the top entry combinationally. Each F1 instruction
// carries a (tos, count) snapshot down the pipe, and EXE restores those
// pointers on a redirect.
//
// Ports
//   clk          clock, all state updates on posedge
//   resetn       asynchronous active-low reset (pointers only, mem not reset)
//   push         predicted call in F1 this cycle
//   push_addr    return address to push (call pc + 8)
//   pop          predicted jr $ra in F1 this cycle
//   top_addr     mem[tos], combinational fetch target for a pop
//   top_valid    stack holds at least one entry
//   full         stack holds DEPTH entries
//   snap_tos     current tos, captured with the F1 instruction
//   snap_cnt     current count, captured with the F1 instruction
//   restore      EXE redirect: reload pointers, drop this cycle's push/pop
//   restore_tos  tos snapshot of the redirecting instruction
//   restore_cnt  count snapshot of the redirecting instruction (<= DEPTH)
// ---------------------------------------------------------------------------
module ret_addr_stack #(
  parameter  int DEPTH    = 8,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                push,
  input  logic [31:0]         push_addr,
  input  logic                pop,
  output logic [31:0]         top_addr,
  output logic                top_valid,
  output logic                full,
  output logic [PTR_BITS-1:0] snap_tos,
  output logic [CNT_BITS-1:0] snap_cnt,
  input  logic                restore,
  input  logic [PTR_BITS-1:0] restore_tos,
  input  logic [CNT_BITS-1:0] restore_cnt
);

  logic [PTR_BITS-1:0] tos;
  logic [PTR_BITS-1:0] tos_inc;
  logic [PTR_BITS-1:0] tos_dec;
  logic [CNT_BITS-1:0] count;
  logic [31:0]         mem [DEPTH];

  logic empty;
  logic is_full;
  logic do_replace;
  logic do_push;
  logic do_pop;

  // DEPTH is a power of two, so the pointer wraps naturally.
  assign tos_inc = tos + PTR_BITS'(1);
  assign tos_dec = tos - PTR_BITS'(1);

  assign empty   = (count == '0);
  assign is_full = (count == CNT_BITS'(DEPTH));

  // Restore wins over everything. Push and pop together on a non-empty stack
  // replace the top in place; on an empty stack the pair degrades to a push.
  assign do_replace = !restore && push && pop && !empty;
  assign do_push    = !restore && push && !do_replace;
  assign do_pop     = !restore && !push && pop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tos   <= '0;
      count <= '0;
    end else if (restore) begin
      tos   <= restore_tos;
      count <= restore_cnt;
    end else if (do_push) begin
      tos <= tos_inc;
      // At full the oldest entry is overwritten and count saturates.
      if (!is_full) count <= count + CNT_BITS'(1);
    end else if (do_pop) begin
      tos   <= tos_dec;
      count <= count - CNT_BITS'(1);
    end
  end

  // Storage is intentionally not reset; top_addr is ignored while empty.
  always_ff @(posedge clk) begin
    if (do_replace) begin
      mem[tos] <= push_addr;
    end else if (do_push) begin
      mem[tos_inc] <= push_addr;
    end
  end

  assign top_addr  = mem[tos];
  assign top_valid = !empty;
  assign full      = is_full;
  assign snap_tos  = tos;
  assign snap_cnt  = count;

`ifndef SYNTHESIS
  restore_cnt_legal: assert property (
    @(posedge clk) disable iff (!resetn)
      restore |-> (restore_cnt <= CNT_BITS'(DEPTH))
  );
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// ---------------------------------------------------------------------------
// tb_ret_addr_stack
// Scoreboard bench: the driver applies one operation per cycle, advances a
// reference model of the stack and queues the expected visible state; a
// separate monitor pops one entry per cycle and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_ret_addr_stack;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic [31:0] top_addr;
  logic        top_valid;
  logic        full;
  logic [2:0]  snap_tos;
  logic [3:0]  snap_cnt;
  logic        restore;
  logic [2:0]  restore_tos;
  logic [3:0]  restore_cnt;

  ret_addr_stack #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_addr  (push_addr),
    .pop        (pop),
    .top_addr   (top_addr),
    .top_valid  (top_valid),
    .full       (full),
    .snap_tos   (snap_tos),
    .snap_cnt   (snap_cnt),
    .restore    (restore),
    .restore_tos(restore_tos),
    .restore_cnt(restore_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        tv;
    bit        full;
    bit [2:0]  tos;
    bit [3:0]  cnt;
    bit [31:0] addr;
    bit        chk_addr;
    bit        spec;
    bit        spec_tv;
    bit [3:0]  spec_cnt;
    bit [31:0] spec_addr;
  } exp_t;

  typedef struct {
    int tos;
    int cnt;
  } snap_t;

  exp_t  sb[$];
  snap_t hist[$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;

  // Reference model: an array of slots, a top index and an entry count.
  bit [31:0] m_mem [DEPTH];
  bit        m_wr  [DEPTH];
  int        m_tos = 0;
  int        m_cnt = 0;

  function automatic void model_op(input bit pu, input bit [31:0] a, input bit po,
                                   input bit rs, input int rt, input int rc);
    if (rs) begin
      m_tos = rt;
      m_cnt = rc;
    end else if (pu && po && m_cnt > 0) begin
      m_mem[m_tos] = a;
    end else if (pu) begin
      m_tos = (m_tos + 1) % DEPTH;
      m_mem[m_tos] = a;
      m_wr[m_tos]  = 1'b1;
      if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
    end else if (po && m_cnt > 0) begin
      m_tos = (m_tos + DEPTH - 1) % DEPTH;
      m_cnt = m_cnt - 1;
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.tv        = (m_cnt != 0);
    e.full      = (m_cnt == DEPTH);
    e.tos       = 3'(m_tos);
    e.cnt       = 4'(m_cnt);
    e.addr      = m_mem[m_tos];
    e.chk_addr  = (m_cnt != 0) && m_wr[m_tos];
    e.spec      = 1'b0;
    e.spec_tv   = 1'b0;
    e.spec_cnt  = '0;
    e.spec_addr = '0;
    sb.push_back(e);
    hist.push_back('{tos: m_tos, cnt: m_cnt});
    if (hist.size() > 16) void'(hist.pop_front());
  endfunction

  // Attach hand-written expectations to the most recently queued cycle.
  function automatic void spec(input bit tv, input int cnt, input bit [31:0] addr);
    int i;
    i = sb.size() - 1;
    sb[i].spec      = 1'b1;
    sb[i].spec_tv   = tv;
    sb[i].spec_cnt  = 4'(cnt);
    sb[i].spec_addr = addr;
  endfunction

  task automatic step(input bit pu, input bit [31:0] a, input bit po,
                      input bit rs = 1'b0, input int rt = 0, input int rc = 0);
    @(negedge clk);
    push        = pu;
    push_addr   = a;
    pop         = po;
    restore     = rs;
    restore_tos = 3'(rt);
    restore_cnt = 4'(rc);
    @(posedge clk);
    model_op(pu, a, po, rs, rt, rc);
    push_expected();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    restore = 1'b0;
    @(posedge clk);
    m_tos = 0;
    m_cnt = 0;
    hist.delete();
    push_expected();
    spec(1'b0, 0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("top_valid", 32'(top_valid), 32'(e.tv));
        cmp("full",      32'(full),      32'(e.full));
        cmp("snap_tos",  32'(snap_tos),  32'(e.tos));
        cmp("snap_cnt",  32'(snap_cnt),  32'(e.cnt));
        if (e.chk_addr) cmp("top_addr", top_addr, e.addr);
        if (e.spec) begin
          cmp("spec_top_valid", 32'(top_valid), 32'(e.spec_tv));
          cmp("spec_snap_cnt",  32'(snap_cnt),  32'(e.spec_cnt));
          if (e.spec_tv) cmp("spec_top_addr", top_addr, e.spec_addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    int r;
    int k;
    snap_t s;
    bit pu;
    bit po;
    bit rs;

    resetn      = 1'b0;
    push        = 1'b0;
    push_addr   = '0;
    pop         = 1'b0;
    restore     = 1'b0;
    restore_tos = '0;
    restore_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 1'b0;
    end

    do_reset();

    // Reset mid-stream after three pushes.
    step(1, 32'hAAA1, 0);
    step(1, 32'hAAA2, 0);
    step(1, 32'hAAA3, 0);
    do_reset();

    // Basic push / pop.
    step(1, 32'h1000, 0);
    step(1, 32'h2000, 0);
    step(1, 32'h3000, 0);  spec(1, 3, 32'h3000);
    step(0, 0, 1);         spec(1, 2, 32'h2000);
    step(0, 0, 1);         spec(1, 1, 32'h1000);
    step(0, 0, 1);         spec(0, 0, 32'h0);

    // Overflow: nine pushes, oldest entry lost.
    do_reset();
    for (int i = 1; i <= 9; i++) step(1, 32'(i * 16), 0);
    spec(1, 8, 32'h90);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1);
      if (i < 8) spec(1, 8 - i, 32'(32'h90 - i * 16));
      else       spec(0, 0, 32'h0);
    end

    // Underflow ignored, then a push.
    step(0, 0, 1);         spec(0, 0, 32'h0);
    step(1, 32'hA0, 0);    spec(1, 1, 32'hA0);

    // Push and pop in the same cycle replace the top.
    do_reset();
    step(1, 32'h100, 0);
    step(1, 32'h200, 0);   spec(1, 2, 32'h200);
    step(1, 32'h500, 1);   spec(1, 2, 32'h500);

    // Restore: fifteen pushes and five pops leave tos=2, count=3.
    do_reset();
    for (int i = 1; i <= 15; i++) step(1, 32'(i * 256), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    spec(1, 3, 32'hA00);
    step(1, 32'hF1, 0);
    step(1, 32'hF2, 0);    spec(1, 5, 32'hF2);
    step(1, 32'hDEAD, 0, 1, 2, 3);
    spec(1, 3, 32'hA00);

    // Randomized traffic; restores reuse recent genuine snapshots.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else begin
        rs = (r < 6) && (hist.size() > 0);
        pu = ($urandom_range(0, 99) < 55);
        po = ($urandom_range(0, 99) < 45);
        if (rs) begin
          k = $urandom_range(0, hist.size() - 1);
          s = hist[k];
        end else begin
          s = '{tos: 0, cnt: 0};
        end
        step(pu, $urandom, po, rs, s.tos, s.cnt);
      end
    end

    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    restore = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
